// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and FSM states for the multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Divide layout: acc = {partial remainder, dividend bits still to shift in / quotient}.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    pr    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    // Remainder stays below the divisor, so a modulo-2^WIDTH subtract is exact when it fits.
    diff  = pr[WIDTH-1:0] - opnd;
    q_bit = 1'b0;
    acc_nxt = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      q_bit   = pr[WIDTH] | (pr[WIDTH-1:0] >= opnd);
      acc_nxt = {(q_bit ? diff : pr[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Fixed latency: start at edge T, FIX (result + done) at edge T+WIDTH+1.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_orig;
  logic               neg_res;
  logic               neg_rem;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] step_nxt;
  logic               step_q;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               fix_dbz;

  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .opnd    (opnd),
    .is_div  (op_q[1]),
    .acc_nxt (step_nxt),
    .q_bit   (step_q)
  );

  // Sign correction; neg_res/neg_rem are only ever set for the signed ops.
  always_comb begin
    prod    = neg_res ? (~acc + 1'b1) : acc;
    quo     = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem     = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    fix_dbz = 1'b0;
    fix_hi  = prod[2*WIDTH-1:WIDTH];
    fix_lo  = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (opnd == '0) begin
        fix_dbz = 1'b1;
        fix_hi  = a_orig;
        fix_lo  = '1;
      end else begin
        fix_hi  = rem;
        fix_lo  = quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= MDU_MULT;
      acc         <= '0;
      opnd        <= '0;
      a_orig      <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            a_orig  <= a;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
            if (op[1]) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc <= {step_nxt[2*WIDTH-1:1], step_nxt[0] | step_q};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          div_by_zero <= fix_dbz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO/div_by_zero and done cycle queued at issue.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic done_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dbz = 1'b0;
    e.cyc = 0;
    case (o)
      MDU_MULT:  p = 64'(sx * sy);
      MDU_MULTU: p = {32'b0, x} * {32'b0, y};
      MDU_DIV: begin
        if (y == 0) begin p = {x, 32'hFFFF_FFFF}; e.dbz = 1'b1; end
        else p = {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) begin p = {x, 32'hFFFF_FFFF}; e.dbz = 1'b1; end
        else p = {x % y, x / y};
      end
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction

  // Result monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (done_d) begin
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("dbz_one_cycle", 64'(div_by_zero), 64'd0);
    end
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("hi", 64'(hi), 64'(mon_e.hi));
        chk("lo", 64'(lo), 64'(mon_e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
    done_d <= done;
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit track, input bit with_lo_we);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    lo_we = with_lo_we; wdata = 32'h0000_DEAD;
    if (track) begin
      e = model(o, x, y);
      e.cyc = cyc + 1 + W + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0; lo_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  logic [1:0]   t_op[6] = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIVU};
  logic [W-1:0] t_a[6]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'h1234};
  logic [W-1:0] t_b[6]  = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0};

  initial begin
    logic [W-1:0] lo_before;
    int           t0;

    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    // Abort an op mid-CALC; no done may follow.
    issue(MDU_MULTU, 32'd9, 32'd9, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("busy_before_abort", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    repeat (40) @(negedge clk);

    issue(MDU_MULTU, 32'd3, 32'd5, 1'b1, 1'b0);
    drain();

    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], 1'b1, 1'b0);
      drain();
    end

    // start while busy and MTLO while busy are both ignored.
    lo_before = lo;
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MDU_MULT; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_mid", 64'(busy), 64'd1);
    repeat (5) @(negedge clk);
    lo_we = 1'b1; wdata = 32'hAA;
    @(posedge clk);
    #1 lo_we = 1'b0;
    chk("mtlo_ignored", 64'(lo), 64'(lo_before));
    drain();

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h55;
    @(posedge clk);
    #1 hi_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h55);
    chk("mthi_lo_kept", 64'(lo), 64'd14);

    issue(MDU_MULTU, 32'd6, 32'd7, 1'b1, 1'b1);
    chk("start_wins_lo", 64'(lo), 64'd14);
    repeat (5) @(negedge clk);
    chk("start_wins_lo_later", 64'(lo), 64'd14);
    drain();

    // Back-to-back: second start at the first edge after FIX.
    issue(MDU_DIVU, 32'd1000, 32'd33, 1'b1, 1'b0);
    t0 = cyc;
    while (cyc < t0 + 32) @(negedge clk);
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd1234567, 1'b1, 1'b0);
    drain();

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom;
      issue(2'($urandom_range(0, 3)), ra, rb, 1'b1, 1'b0);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
